cpu_sram_like_bridge: RTL

- Sits between the MIPS core's per-stage SRAM-style ports (enable, write strobe, address, write data, read data) and an SRAM-like handshake bus (req, addr_ok, data_ok).
- Provides two independent channels, instruction and data. Each channel holds at most one outstanding transaction.
- Each channel generates a stall back to the core and holds returned read data while the pipeline is frozen.
- Successor to the fixed always-ready SRAM top: parametrised widths, multi-cycle memory latency, optional kseg address translation.

---
 rtl/mycpu_bus_pkg.sv | 42 ++++
 rtl/sram_like_channel.sv | 127 ++++++++++++
 rtl/cpu_sram_like_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mycpu_bus_pkg.sv
// mycpu_bus_pkg
// Shared definitions for the CPU-to-SRAM-like bus bridge:
//   - chan_state_e : per-channel handshake state (IDLE/ADDR/DATA/DONE)
//   - SIZE_*       : bus transfer size codes (log2 of bytes)
//   - KSEG*        : MIPS kseg0/kseg1 segment constants used by address translation
//   - strb_to_size : converts a byte-strobe pattern into a bus size code
package mycpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } chan_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
   localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
   localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

   // Strobes narrower than 8 bits are zero-extended by the caller. Only
   // naturally aligned contiguous runs of 1, 2, 4 or 8 bytes map to a smaller
   // size; reads (all-zero) and irregular patterns fall back to the full width.
   function automatic logic [1:0] strb_to_size(input logic [7:0] wen,
                                               input logic [1:0] fullSize);
      logic [1:0] size;
      logic [8:0] mask;
      size = fullSize;
      for (int s = 0; s < 4; s++) begin
         mask = (9'd1 << (1 << s)) - 9'd1;
         for (int k = 0; k < 8; k += (1 << s)) begin
            if (wen == (mask[7:0] << k)) size = s[1:0];
         end
      end
      return size;
   endfunction

endpackage

// File: rtl/sram_like_channel.sv
// sram_like_channel
// One SRAM-like bus channel with at most one outstanding transaction.
// Converts a core-side enable/strobe/address request into a req/addr_ok/data_ok
// handshake, stalls the core until the response arrives, and keeps the returned
// data in a hold register while the pipeline is frozen.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   stall_all_i              core pipeline frozen
//   en_i, wen_i, addr_i,     core request (addr_i already physical)
//   wdata_i, uncached_i
//   rdata_o, stall_o         core response data and stall
//   req_o, wr_o, size_o,     bus request fields (registered)
//   addr_o, wdata_o
//   addr_ok_i, data_ok_i,    bus handshake and response data
//   rdata_i
//   uncached_o               uncached attribute of the captured request
module sram_like_channel
   import mycpu_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_all_i,
   input  logic              en_i,
   input  logic [STRB_W-1:0] wen_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              uncached_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              req_o,
   output logic              wr_o,
   output logic [1:0]        size_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic              addr_ok_i,
   input  logic              data_ok_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              uncached_o
);

   localparam logic [1:0] FULL_SIZE = 2'($clog2(STRB_W));

   chan_state_e       state_q;
   logic              req_q;
   logic              wr_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] hold_q;
   logic              uncached_q;
   logic              complete;

   // A transaction finishes either when the slave accepts and answers in the
   // same cycle, or when the answer arrives while waiting in DATA. Responses
   // seen in IDLE or DONE never count, which also drops stale replies after reset.
   always_comb begin
      complete = ((state_q == ADDR) && addr_ok_i && data_ok_i) ||
                 ((state_q == DATA) && data_ok_i);
      stall_o  = en_i && !(complete || (state_q == DONE));
      rdata_o  = complete ? rdata_i : hold_q;
   end

   // Handshake FSM with its capture and hold registers. Request fields are
   // frozen on leaving IDLE so the bus sees stable values until addr_ok.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         wr_q       <= 1'b0;
         size_q     <= SIZE_B;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= '0;
         uncached_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en_i) begin
                  state_q    <= ADDR;
                  req_q      <= 1'b1;
                  wr_q       <= |wen_i;
                  size_q     <= strb_to_size(8'(wen_i), FULL_SIZE);
                  addr_q     <= addr_i;
                  wdata_q    <= wdata_i;
                  uncached_q <= uncached_i;
               end
            end
            ADDR: begin
               if (addr_ok_i) begin
                  req_q <= 1'b0;
                  if (data_ok_i) begin
                     hold_q  <= rdata_i;
                     state_q <= stall_all_i ? DONE : IDLE;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (data_ok_i) begin
                  hold_q  <= rdata_i;
                  state_q <= stall_all_i ? DONE : IDLE;
               end
            end
            DONE: begin
               if (!stall_all_i) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_o      = req_q;
   assign wr_o       = wr_q;
   assign size_o     = size_q;
   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign uncached_o = uncached_q;

endmodule

// File: rtl/cpu_sram_like_bridge.sv
// cpu_sram_like_bridge
// Bridges the MIPS core's SRAM-style instruction and data ports onto two
// independent SRAM-like handshake channels (req/addr_ok/data_ok).
// Optional macro MMU_KSEG_EN (ADDR_W=32 only): kseg0/kseg1 virtual addresses
// are mapped to physical by clearing bits [31:29], and data_uncached flags
// kseg1. Without the macro addresses pass through and data_uncached is 0.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   cpu_stall_all                     core pipeline frozen
//   cpu_inst_* / cpu_data_*           core-side request, response and stall
//   inst_* / data_*                   SRAM-like bus channels
//   data_uncached                     captured data address is uncached
module cpu_sram_like_bridge
   import mycpu_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_stall_all,
   input  logic              cpu_inst_en,
   input  logic [ADDR_W-1:0] cpu_inst_addr,
   output logic [DATA_W-1:0] cpu_inst_rdata,
   output logic              cpu_inst_stall,
   input  logic              cpu_data_en,
   input  logic [STRB_W-1:0] cpu_data_wen,
   input  logic [ADDR_W-1:0] cpu_data_addr,
   input  logic [DATA_W-1:0] cpu_data_wdata,
   output logic [DATA_W-1:0] cpu_data_rdata,
   output logic              cpu_data_stall,
   output logic              inst_req,
   output logic              inst_wr,
   output logic [1:0]        inst_size,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_wdata,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [DATA_W-1:0] inst_rdata,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic              data_uncached
);

   logic [ADDR_W-1:0] instPaddr;
   logic [ADDR_W-1:0] dataPaddr;
   logic              dataUncachedSeg;
   logic              unusedInstUncached;

`ifdef MMU_KSEG_EN
   // kseg0 and kseg1 (0x8000_0000-0xBFFF_FFFF) both alias the low 512 MB of
   // physical space; kseg1 is the uncached window.
   always_comb begin
      instPaddr = cpu_inst_addr;
      dataPaddr = cpu_data_addr;
      if (cpu_inst_addr[31:30] == KSEG0_BASE[31:30]) instPaddr = cpu_inst_addr & KSEG_MASK;
      if (cpu_data_addr[31:30] == KSEG0_BASE[31:30]) dataPaddr = cpu_data_addr & KSEG_MASK;
      dataUncachedSeg = (cpu_data_addr[31:29] == KSEG1_BASE[31:29]);
   end
`else
   // No translation: virtual and physical addresses are identical.
   always_comb begin
      instPaddr       = cpu_inst_addr;
      dataPaddr       = cpu_data_addr;
      dataUncachedSeg = 1'b0;
   end
`endif

   // Instruction channel never writes, so its strobes and store data are tied off.
   sram_like_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .STRB_W (STRB_W)
   ) u_inst_chan (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .stall_all_i (cpu_stall_all),
      .en_i        (cpu_inst_en),
      .wen_i       ('0),
      .addr_i      (instPaddr),
      .wdata_i     ('0),
      .uncached_i  (1'b0),
      .rdata_o     (cpu_inst_rdata),
      .stall_o     (cpu_inst_stall),
      .req_o       (inst_req),
      .wr_o        (inst_wr),
      .size_o      (inst_size),
      .addr_o      (inst_addr),
      .wdata_o     (inst_wdata),
      .addr_ok_i   (inst_addr_ok),
      .data_ok_i   (inst_data_ok),
      .rdata_i     (inst_rdata),
      .uncached_o  (unusedInstUncached)
   );

   // Data channel carries loads and stores.
   sram_like_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .STRB_W (STRB_W)
   ) u_data_chan (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .stall_all_i (cpu_stall_all),
      .en_i        (cpu_data_en),
      .wen_i       (cpu_data_wen),
      .addr_i      (dataPaddr),
      .wdata_i     (cpu_data_wdata),
      .uncached_i  (dataUncachedSeg),
      .rdata_o     (cpu_data_rdata),
      .stall_o     (cpu_data_stall),
      .req_o       (data_req),
      .wr_o        (data_wr),
      .size_o      (data_size),
      .addr_o      (data_addr),
      .wdata_o     (data_wdata),
      .addr_ok_i   (data_addr_ok),
      .data_ok_i   (data_data_ok),
      .rdata_i     (data_rdata),
      .uncached_o  (data_uncached)
   );

endmodule
